// File: rtl/sale_terminal_pkg.sv
// Constants and types shared by the sale-terminal barcode entry and hover stages.
// The product barcode table must stay identical between the two stages.
package sale_terminal_pkg;

  localparam int NUM_PRODUCTS = 12;

  localparam logic [15:0] PRDCT_BARCODE [NUM_PRODUCTS] = '{
    16'h3124, 16'h4132, 16'h4133, 16'h3121, 16'h3133, 16'h3214,
    16'h2134, 16'h2144, 16'h3112, 16'h4321, 16'h1342, 16'h1213
  };

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_SUBMIT = 2'd1,
    ST_ERROR  = 2'd2
  } entry_state_t;

  // Nibble 0 is the leftmost digit, bits [15:12].
  function automatic logic [15:0] set_nibble(input logic [15:0] bc,
                                             input logic [1:0]  pos,
                                             input logic [3:0]  val);
    logic [15:0] mask;
    mask = 16'hF000 >> {pos, 2'b00};
    return (bc & ~mask) | ({val, 12'h000} >> {pos, 2'b00});
  endfunction

endpackage

// File: rtl/barcode_product_lookup.sv
// Combinational full-width match of an entered barcode against the product table.
// The lowest matching index wins.
module barcode_product_lookup
  import sale_terminal_pkg::*;
(
  input  logic [15:0] i_barcode,
  output logic        o_hit,
  output logic [3:0]  o_idx
);

  always_comb begin
    o_hit = 1'b0;
    o_idx = 4'd0;
    for (int i = NUM_PRODUCTS - 1; i >= 0; i--) begin
      if (i_barcode == PRDCT_BARCODE[i]) begin
        o_hit = 1'b1;
        o_idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/barcode_entry_buffer.sv
// Keypad entry buffer: gathers up to four BCD digits, submits on enter and
// either pulses a product select or holds a timed error lockout.
module barcode_entry_buffer
  import sale_terminal_pkg::*;
#(
  parameter int ERR_HOLD = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_back,
  input  logic        key_clear,
  input  logic        key_enter,
  output logic [15:0] Barcode_out,
  output logic [2:0]  NumOfBarcodeDigitsEntered,
  output logic        product_valid,
  output logic [3:0]  product_idx,
  output logic        entry_reject,
  output logic        error_flag
);

  localparam int CW = $clog2(ERR_HOLD + 1);
  localparam logic [CW-1:0] LP_ERR_LOAD = CW'(ERR_HOLD - 1);

  entry_state_t  r_state;
  logic [15:0]   r_barcode;
  logic [2:0]    r_count;
  logic          r_product_valid;
  logic [3:0]    r_product_idx;
  logic          r_entry_reject;
  logic          r_error_flag;
  logic [CW-1:0] r_err_cnt;

  logic          w_hit;
  logic [3:0]    w_idx;
  logic          w_digit_ok;
  logic [1:0]    w_back_pos;

  barcode_product_lookup u_lookup (
    .i_barcode (r_barcode),
    .o_hit     (w_hit),
    .o_idx     (w_idx)
  );

  assign w_digit_ok = key_valid && (key_digit >= 4'd1) && (key_digit <= 4'd4)
                      && (r_count < 3'd4);
  assign w_back_pos = r_count[1:0] - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_ENTRY;
      r_barcode       <= 16'h0000;
      r_count         <= 3'd0;
      r_product_valid <= 1'b0;
      r_product_idx   <= 4'd0;
      r_entry_reject  <= 1'b0;
      r_error_flag    <= 1'b0;
      r_err_cnt       <= '0;
    end else begin
      r_product_valid <= 1'b0;
      r_entry_reject  <= 1'b0;
      case (r_state)
        ST_ENTRY: begin
          if (key_clear) begin
            r_barcode <= 16'h0000;
            r_count   <= 3'd0;
          end else if (key_enter) begin
            if (r_count == 3'd4) begin
              if (w_hit) begin
                r_state         <= ST_SUBMIT;
                r_product_valid <= 1'b1;
                r_product_idx   <= w_idx;
              end else begin
                r_state      <= ST_ERROR;
                r_error_flag <= 1'b1;
                r_err_cnt    <= LP_ERR_LOAD;
              end
            end else begin
              r_entry_reject <= 1'b1;
            end
          end else if (key_back) begin
            if (r_count != 3'd0) begin
              r_barcode <= set_nibble(r_barcode, w_back_pos, 4'h0);
              r_count   <= r_count - 3'd1;
            end
          end else if (w_digit_ok) begin
            r_barcode <= set_nibble(r_barcode, r_count[1:0], key_digit);
            r_count   <= r_count + 3'd1;
          end
        end
        ST_SUBMIT: begin
          r_state   <= ST_ENTRY;
          r_barcode <= 16'h0000;
          r_count   <= 3'd0;
        end
        ST_ERROR: begin
          // Buffer stays visible until the lockout ends or the buyer clears.
          if (key_clear || (r_err_cnt == '0)) begin
            r_state      <= ST_ENTRY;
            r_error_flag <= 1'b0;
            r_err_cnt    <= '0;
            r_barcode    <= 16'h0000;
            r_count      <= 3'd0;
          end else begin
            r_err_cnt <= r_err_cnt - 1'b1;
          end
        end
        default: r_state <= ST_ENTRY;
      endcase
    end
  end

  assign Barcode_out               = r_barcode;
  assign NumOfBarcodeDigitsEntered = r_count;
  assign product_valid             = r_product_valid;
  assign product_idx               = r_product_idx;
  assign entry_reject              = r_entry_reject;
  assign error_flag                = r_error_flag;

endmodule

// File: tb/tb_barcode_entry_buffer.sv
// Scoreboard bench for barcode_entry_buffer: a digit-list reference model
// predicts every cycle's outputs and a monitor compares them against the DUT.
module tb_barcode_entry_buffer;

  localparam int ERR_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        key_back = 1'b0;
  logic        key_clear = 1'b0;
  logic        key_enter = 1'b0;
  logic [15:0] Barcode_out;
  logic [2:0]  NumOfBarcodeDigitsEntered;
  logic        product_valid;
  logic [3:0]  product_idx;
  logic        entry_reject;
  logic        error_flag;

  barcode_entry_buffer #(.ERR_HOLD(ERR_HOLD)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .key_valid                 (key_valid),
    .key_digit                 (key_digit),
    .key_back                  (key_back),
    .key_clear                 (key_clear),
    .key_enter                 (key_enter),
    .Barcode_out               (Barcode_out),
    .NumOfBarcodeDigitsEntered (NumOfBarcodeDigitsEntered),
    .product_valid             (product_valid),
    .product_idx               (product_idx),
    .entry_reject              (entry_reject),
    .error_flag                (error_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bc;
    logic [2:0]  cnt;
    logic        pv;
    logic [3:0]  idx;
    logic        rej;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: a plain list of entered digits plus a mode word.
  int   m_digits[$];
  int   m_mode = 0;          // 0 entry, 1 submit, 2 error
  int   m_err_left = 0;
  int   m_last_idx = 0;
  int   m_rej = 0;
  int   products[12] = '{'h3124, 'h4132, 'h4133, 'h3121, 'h3133, 'h3214,
                         'h2134, 'h2144, 'h3112, 'h4321, 'h1342, 'h1213};

  function automatic int digits_value(input int d[$]);
    int v = 0;
    for (int i = 0; i < d.size(); i++) v += d[i] * (1 << (12 - 4 * i));
    return v;
  endfunction

  task automatic model_step(input bit r, input bit v, input int d,
                            input bit b, input bit c, input bit e);
    m_rej = 0;
    if (r) begin
      m_digits.delete(); m_mode = 0; m_err_left = 0; m_last_idx = 0;
      return;
    end
    case (m_mode)
      0: begin
        if (c) m_digits.delete();
        else if (e) begin
          if (m_digits.size() == 4) begin
            int found = -1;
            for (int i = 0; i < 12; i++)
              if (found < 0 && products[i] == digits_value(m_digits)) found = i;
            if (found >= 0) begin m_mode = 1; m_last_idx = found; end
            else begin m_mode = 2; m_err_left = ERR_HOLD; end
          end else m_rej = 1;
        end else if (b) begin
          if (m_digits.size() > 0) void'(m_digits.pop_back());
        end else if (v && d >= 1 && d <= 4 && m_digits.size() < 4)
          m_digits.push_back(d);
      end
      1: begin m_digits.delete(); m_mode = 0; end
      default: begin
        if (c) begin m_digits.delete(); m_mode = 0; end
        else begin
          m_err_left--;
          if (m_err_left == 0) begin m_digits.delete(); m_mode = 0; end
        end
      end
    endcase
  endtask

  task automatic cyc(input bit r, input bit v, input int d,
                     input bit b, input bit c, input bit e);
    exp_t x;
    @(posedge clk);
    #3;
    rst = r; key_valid = v; key_digit = 4'(d);
    key_back = b; key_clear = c; key_enter = e;
    model_step(r, v, d, b, c, e);
    x.bc  = 16'(digits_value(m_digits));
    x.cnt = 3'(m_digits.size());
    x.pv  = (m_mode == 1);
    x.idx = 4'(m_last_idx);
    x.rej = (m_rej != 0);
    x.err = (m_mode == 2);
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic digit(input int d);
    cyc(0, 1, d, 0, 0, 0);
  endtask

  task automatic type_code(input int code);
    for (int i = 3; i >= 0; i--) digit((code >> (4 * i)) & 'hF);
  endtask

  // Monitor: compares the DUT against the oldest prediction once per cycle.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_tests++;
        if (Barcode_out !== x.bc || NumOfBarcodeDigitsEntered !== x.cnt ||
            product_valid !== x.pv || product_idx !== x.idx ||
            entry_reject !== x.rej || error_flag !== x.err) begin
          n_fail++;
          $display("FAIL outputs @%0t: got bc=%h cnt=%0d pv=%b idx=%0d rej=%b err=%b, expected bc=%h cnt=%0d pv=%b idx=%0d rej=%b err=%b",
                   $time, Barcode_out, NumOfBarcodeDigitsEntered, product_valid,
                   product_idx, entry_reject, error_flag,
                   x.bc, x.cnt, x.pv, x.idx, x.rej, x.err);
        end
      end
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // Product 0 hit
    type_code('h3124); cyc(0, 0, 0, 0, 0, 1); idle(3);
    // Entry with backspace, ends at product 11
    digit(1); digit(2); digit(1); cyc(0, 0, 0, 1, 0, 0);
    digit(1); digit(3); cyc(0, 0, 0, 0, 0, 1); idle(2);
    // Unknown barcode, digits pressed during lockout
    type_code('h4444); cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < ERR_HOLD + 2; i++) digit(1 + (i % 4));
    idle(2);
    // Illegal digit, fifth digit, short enter, back at zero
    digit(5); digit(0); digit(2); digit(3);
    cyc(0, 0, 0, 0, 0, 1); idle(1);
    digit(1); digit(1); digit(4); cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0); cyc(0, 0, 0, 1, 0, 0);
    // Priority: clear beats digit; enter beats back
    digit(4); cyc(0, 1, 2, 0, 1, 0);
    digit(3); cyc(0, 1, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    // Clear during error
    type_code('h1111); cyc(0, 0, 0, 0, 0, 1); idle(3);
    cyc(0, 0, 0, 0, 1, 0); idle(1);
    // Reset mid-error and reset while in submit
    type_code('h2222); cyc(0, 0, 0, 0, 0, 1); idle(2);
    cyc(1, 0, 0, 0, 0, 0); idle(1);
    type_code('h4321); cyc(0, 0, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 0); idle(1);

    for (int n = 0; n < 3000; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 2) cyc(1, 0, 0, 0, 0, 0);
      else if (r < 7) begin
        cyc(0, 0, 0, 0, 1, 0);
        type_code(products[$urandom_range(0, 11)]);
        cyc(0, 0, 0, 0, 0, 1);
      end else begin
        int d = ($urandom_range(0, 99) < 15) ? $urandom_range(0, 15)
                                               : $urandom_range(1, 4);
        cyc(0, $urandom_range(0, 99) < 45, d,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 10);
      end
    end
    idle(1);

    @(posedge clk); #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
